// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory read-port arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 256;

  // Requester indices: instruction-cache refill and data-cache refill.
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY0   = 2'd1,
    BUSY1   = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational 2-way request picker.
// MEM_READ_ARB_RR_EN defined: round-robin on collision (port != last_grant wins).
// Undefined: fixed priority, port 1 over port 0.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant_vld,
  output logic grant_id
);

  // Choose a winner among the pending requests.
  always_comb begin
    grant_vld = req0 | req1;
    grant_id  = PORT_I;
`ifdef MEM_READ_ARB_RR_EN
    if (req0 && req1) begin
      grant_id = ~last_grant;
    end else if (req1) begin
      grant_id = PORT_D;
    end
`else
    if (req1) begin
      grant_id = PORT_D;
    end
`endif
  end

`ifndef MEM_READ_ARB_RR_EN
  // History input is meaningless under fixed priority.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/mem_read_arbiter.sv
// Shares one cache-line memory read port between the I-cache (port 0) and
// D-cache (port 1) refill engines. One grant at a time; the granted address
// is latched and held until the line returns or the grant times out.
// Optional: MEM_READ_ARB_RR_EN selects round-robin arbitration.
module mem_read_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 11
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              req0_en,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_valid,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_en,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_valid,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err_timeout
);

  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT);

  arb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              last_grant;
  logic              grant_vld;
  logic              grant_id;

`ifdef MEM_READ_ARB_RR_EN
  logic last_grant_q, last_grant_d;
  assign last_grant = last_grant_q;
`else
  assign last_grant = PORT_I;
`endif

  mem_arb_pick u_pick (
    .req0       (req0_en),
    .req1       (req1_en),
    .last_grant (last_grant),
    .grant_vld  (grant_vld),
    .grant_id   (grant_id)
  );

  // Data is broadcast; requesters qualify it with their own valid.
  assign req0_rdata  = mem_rdata;
  assign req1_rdata  = mem_rdata;
  assign mem_addr    = addr_q;
  assign err_timeout = err_q;

  // Next-state, grant latching, timeout counting and valid routing.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
`ifdef MEM_READ_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    mem_en     = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          addr_d  = grant_id ? req1_addr : req0_addr;
          state_d = grant_id ? BUSY1 : BUSY0;
          cnt_d   = '0;
`ifdef MEM_READ_ARB_RR_EN
          last_grant_d = grant_id;
`endif
        end
      end
      BUSY0, BUSY1: begin
        mem_en = 1'b1;
        if (mem_valid) begin
          // A requester that dropped en mid-grant simply gets no valid.
          req0_valid = (state_q == BUSY0) & req0_en;
          req1_valid = (state_q == BUSY1) & req1_en;
          state_d    = RELEASE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if ((TIMEOUT != 0) && (cnt_d == TO_LIMIT)) begin
            err_d   = 1'b1;
            state_d = RELEASE;
          end
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
`ifdef MEM_READ_ARB_RR_EN
      last_grant_q <= PORT_I;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`ifdef MEM_READ_ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

endmodule
